// File: rtl/ack_gen_pkg.sv
// Shared constants and types for the multi-outstanding acknowledge generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ack_gen_pkg;

  localparam int ACK_ID_W       = 4;
  localparam int ACK_MAX_STAGES = 16;

  // Outstanding counter must represent 0..max_out inclusive.
  function automatic int ack_cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  typedef struct packed {
    logic                v;
    logic [ACK_ID_W-1:0] id;
  } ack_ent_t;

endpackage

// File: rtl/ack_delay_ctr.sv
// One acknowledge path: ID delay line, outstanding counter, full flag, sticky drop flag.
// Latency: STAGES ce-qualified cycles from accept to ack.
// Backpressure: full_o when MAX_OUT in flight; requests seen while full are dropped and flagged.
module ack_delay_ctr
  import ack_gen_pkg::*;
#(
  parameter int STAGES  = 3,
  parameter int ID_W    = ACK_ID_W,
  parameter int MAX_OUT = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic            req_i,
  input  logic [ID_W-1:0] id_i,
  output logic            full_o,
  output logic            ack_o,
  output logic [ID_W-1:0] ack_id_o,
  output logic            ovf_o
);

  localparam int CW = ack_cnt_w(MAX_OUT);

  logic [STAGES-1:0]           v_q;
  logic [STAGES-1:0][ID_W-1:0] id_q;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_nxt;
  logic                        full_q;
  logic                        ovf_q;
  logic                        accept;
  logic                        retire;

  // full is taken from the register, so a same-cycle retire never unblocks a request.
  assign accept = req_i & ce_i & ~full_q;
  assign retire = v_q[STAGES-1] & ce_i;

  // Shift the valid/ID pipeline on every enabled edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q  <= '0;
      id_q <= '0;
    end else if (ce_i) begin
      v_q[0]  <= accept;
      id_q[0] <= id_i;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        id_q[k] <= id_q[k-1];
      end
    end
  end

  // Next outstanding count: accept and retire together cancel out.
  always_comb begin
    cnt_nxt = cnt_q;
    case ({accept, retire})
      2'b10:   cnt_nxt = cnt_q + CW'(1);
      2'b01:   cnt_nxt = cnt_q - CW'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  // Counter, registered full compare and sticky drop flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ce_i) begin
      cnt_q  <= cnt_nxt;
      full_q <= (cnt_nxt == CW'(MAX_OUT));
      if (req_i && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign full_o   = full_q;
  assign ovf_o    = ovf_q;
  assign ack_o    = retire;
  // ID is zeroed outside an acknowledge so idle outputs stay quiet.
  assign ack_id_o = retire ? id_q[STAGES-1] : '0;

endmodule

// File: rtl/ack_gen_mo.sv
// Read/write ID-tagged acknowledge generator; ACK_GEN_MO_REG_OUT_EN adds an output register stage.
// Latency: READ_STAGES / WRITE_STAGES ce cycles (+1 with ACK_GEN_MO_REG_OUT_EN).
// Backpressure: rfull_o / wfull_o at MAX_OUT outstanding; dropped requests set sticky rovf_o / wovf_o.
module ack_gen_mo
  import ack_gen_pkg::*;
#(
  parameter int ID_W         = ACK_ID_W,
  parameter int READ_STAGES  = 3,
  parameter int WRITE_STAGES = 1,
  parameter int MAX_OUT      = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic            rreq_i,
  input  logic [ID_W-1:0] rid_i,
  input  logic            wreq_i,
  input  logic [ID_W-1:0] wid_i,
  output logic            rfull_o,
  output logic            wfull_o,
  output logic            rack_o,
  output logic [ID_W-1:0] rack_id_o,
  output logic            wack_o,
  output logic [ID_W-1:0] wack_id_o,
  output logic            ack_o,
  output logic            rovf_o,
  output logic            wovf_o
);

  logic            r_ack;
  logic [ID_W-1:0] r_ack_id;
  logic            w_ack;
  logic [ID_W-1:0] w_ack_id;

  ack_delay_ctr #(
    .STAGES  (READ_STAGES),
    .ID_W    (ID_W),
    .MAX_OUT (MAX_OUT)
  ) u_rd (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ce_i     (ce_i),
    .req_i    (rreq_i),
    .id_i     (rid_i),
    .full_o   (rfull_o),
    .ack_o    (r_ack),
    .ack_id_o (r_ack_id),
    .ovf_o    (rovf_o)
  );

  ack_delay_ctr #(
    .STAGES  (WRITE_STAGES),
    .ID_W    (ID_W),
    .MAX_OUT (MAX_OUT)
  ) u_wr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ce_i     (ce_i),
    .req_i    (wreq_i),
    .id_i     (wid_i),
    .full_o   (wfull_o),
    .ack_o    (w_ack),
    .ack_id_o (w_ack_id),
    .ovf_o    (wovf_o)
  );

`ifdef ACK_GEN_MO_REG_OUT_EN
  logic            rack_q;
  logic [ID_W-1:0] rack_id_q;
  logic            wack_q;
  logic [ID_W-1:0] wack_id_q;

  // Capture acknowledges on enabled edges; the counters already retired them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rack_q    <= 1'b0;
      rack_id_q <= '0;
      wack_q    <= 1'b0;
      wack_id_q <= '0;
    end else if (ce_i) begin
      rack_q    <= r_ack;
      rack_id_q <= r_ack_id;
      wack_q    <= w_ack;
      wack_id_q <= w_ack_id;
    end
  end

  // Still qualified by ce_i so a stall cannot replay a held acknowledge.
  assign rack_o    = rack_q & ce_i;
  assign rack_id_o = rack_o ? rack_id_q : '0;
  assign wack_o    = wack_q & ce_i;
  assign wack_id_o = wack_o ? wack_id_q : '0;
`else
  assign rack_o    = r_ack;
  assign rack_id_o = r_ack_id;
  assign wack_o    = w_ack;
  assign wack_id_o = w_ack_id;
`endif

  assign ack_o = rack_o | wack_o;

endmodule

// File: tb/tb_ack_gen_mo.sv
module tb_ack_gen_mo;

  localparam int RS = 3;
  localparam int WS = 2;
  localparam int MO = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ce_i;
  logic       rreq_i;
  logic [3:0] rid_i;
  logic       wreq_i;
  logic [3:0] wid_i;
  logic       rfull_o, wfull_o, rack_o, wack_o, ack_o, rovf_o, wovf_o;
  logic [3:0] rack_id_o, wack_id_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ack_gen_mo #(
    .ID_W         (4),
    .READ_STAGES  (RS),
    .WRITE_STAGES (WS),
    .MAX_OUT      (MO)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ce_i      (ce_i),
    .rreq_i    (rreq_i),
    .rid_i     (rid_i),
    .wreq_i    (wreq_i),
    .wid_i     (wid_i),
    .rfull_o   (rfull_o),
    .wfull_o   (wfull_o),
    .rack_o    (rack_o),
    .rack_id_o (rack_id_o),
    .wack_o    (wack_o),
    .wack_id_o (wack_id_o),
    .ack_o     (ack_o),
    .rovf_o    (rovf_o),
    .wovf_o    (wovf_o)
  );

  typedef struct {
    logic       ce;
    logic       rreq;
    logic [3:0] rid;
    logic       wreq;
    logic [3:0] wid;
    logic       rack;
    logic [3:0] rack_id;
    logic       wack;
    logic [3:0] wack_id;
    logic       rfull;
    logic       wfull;
    logic       rovf;
    logic       wovf;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] id;
  } ent_t;

  vec_t tbl[16];
  ent_t rq[$];
  ent_t wq[$];

  function automatic vec_t mk(input logic ce, input logic rreq, input logic [3:0] rid,
                              input logic wreq, input logic [3:0] wid,
                              input logic rack, input logic [3:0] rack_id,
                              input logic wack, input logic [3:0] wack_id,
                              input logic rfull, input logic wfull,
                              input logic rovf, input logic wovf);
    vec_t v;
    v.ce = ce; v.rreq = rreq; v.rid = rid; v.wreq = wreq; v.wid = wid;
    v.rack = rack; v.rack_id = rack_id; v.wack = wack; v.wack_id = wack_id;
    v.rfull = rfull; v.wfull = wfull; v.rovf = rovf; v.wovf = wovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, " rack"},    rack_o,    e.rack);
    chk({tag, " rack_id"}, rack_id_o, e.rack_id);
    chk({tag, " wack"},    wack_o,    e.wack);
    chk({tag, " wack_id"}, wack_id_o, e.wack_id);
    chk({tag, " ack"},     ack_o,     e.rack | e.wack);
    chk({tag, " rfull"},   rfull_o,   e.rfull);
    chk({tag, " wfull"},   wfull_o,   e.wfull);
    chk({tag, " rovf"},    rovf_o,    e.rovf);
    chk({tag, " wovf"},    wovf_o,    e.wovf);
  endtask

  task automatic idle_inputs();
    ce_i = 1'b1; rreq_i = 1'b0; rid_i = '0; wreq_i = 1'b0; wid_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    vec_t zero;
    vec_t e;
    int   tick;
    logic m_rovf, m_wovf;

    // cycle-by-cycle expectations, READ_STAGES=3, WRITE_STAGES=2, MAX_OUT=2
    //            ce rq rid wq wid | rack id wack id rfull wfull rovf wovf
    tbl[0]  = mk(1, 1, 5, 1, 9,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 2, 0, 0,    0, 0, 1, 9, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0,    1, 5, 0, 0, 1, 0, 1, 0);
    tbl[4]  = mk(1, 1, 3, 0, 0,    1, 1, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 4, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 0, 0, 1, 6,    0, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0,    1, 3, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 0,    0, 0, 1, 6, 0, 0, 1, 0);
    tbl[11] = mk(1, 0, 0, 1, 2,    0, 0, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(1, 0, 0, 1, 3,    0, 0, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 0, 0, 1, 4,    0, 0, 1, 2, 0, 1, 1, 0);
    tbl[14] = mk(1, 0, 0, 0, 0,    0, 0, 1, 3, 0, 0, 1, 1);
    tbl[15] = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 1);
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset values, sampled while reset is held
    rst_ni = 1'b0;
    idle_inputs();
    rreq_i = 1'b1; rid_i = 4'd5; wreq_i = 1'b1; wid_i = 4'd9;
    repeat (3) @(negedge clk_i);
    #1 chk_all("reset", zero);
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // directed table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      ce_i = tbl[i].ce; rreq_i = tbl[i].rreq; rid_i = tbl[i].rid;
      wreq_i = tbl[i].wreq; wid_i = tbl[i].wid;
      #1 chk_all($sformatf("tbl%0d", i), tbl[i]);
    end

    // reset mid-flight discards read ID 7
    do_reset();
    @(negedge clk_i);
    rreq_i = 1'b1; rid_i = 4'd7;
    @(negedge clk_i);
    rreq_i = 1'b0;
    #2 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #1;
      chk($sformatf("midrst%0d rack", i), rack_o, 1'b0);
      chk($sformatf("midrst%0d rfull", i), rfull_o, 1'b0);
    end
    // counter restarted at zero: one read must leave rfull low, two must set it
    @(negedge clk_i);
    rreq_i = 1'b1; rid_i = 4'd1;
    @(negedge clk_i);
    rid_i = 4'd2;
    #1 chk("midrst cnt1 rfull", rfull_o, 1'b0);
    @(negedge clk_i);
    rreq_i = 1'b0;
    #1 chk("midrst cnt2 rfull", rfull_o, 1'b1);
    chk("midrst rovf", rovf_o, 1'b0);
    repeat (4) @(negedge clk_i);

    // randomized run against a queue-based reference
    do_reset();
    rq.delete(); wq.delete();
    tick = 0; m_rovf = 1'b0; m_wovf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic rfull_e, wfull_e, racc, wacc;
      @(negedge clk_i);
      ce_i   = ($urandom_range(0, 5) != 0);
      rreq_i = ($urandom_range(0, 2) != 0);
      rid_i  = 4'($urandom_range(0, 15));
      wreq_i = ($urandom_range(0, 2) != 0);
      wid_i  = 4'($urandom_range(0, 15));
      #1;
      rfull_e   = (rq.size() == MO);
      wfull_e   = (wq.size() == MO);
      e         = zero;
      e.rack    = ce_i && rq.size() > 0 && rq[0].due == tick;
      e.rack_id = e.rack ? rq[0].id : 4'd0;
      e.wack    = ce_i && wq.size() > 0 && wq[0].due == tick;
      e.wack_id = e.wack ? wq[0].id : 4'd0;
      e.rfull   = rfull_e;
      e.wfull   = wfull_e;
      e.rovf    = m_rovf;
      e.wovf    = m_wovf;
      chk_all($sformatf("rnd%0d", c), e);
      if (ce_i) begin
        racc = rreq_i && !rfull_e;
        wacc = wreq_i && !wfull_e;
        if (e.rack) void'(rq.pop_front());
        if (e.wack) void'(wq.pop_front());
        if (racc) rq.push_back('{due: tick + RS, id: rid_i});
        if (wacc) wq.push_back('{due: tick + WS, id: wid_i});
        if (rreq_i && rfull_e) m_rovf = 1'b1;
        if (wreq_i && wfull_e) m_wovf = 1'b1;
        tick++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
